pixel_filter_pipe: RTL and testbench

Parametrised, pipelined per-pixel colour filter for the VGA video path. It applies per-channel masking and then one of four modes: passthrough, grayscale, invert or threshold. Unlike the earlier combinational filter, the configuration is synchronised and only changes at frame boundaries, so a switch change never tears a frame. It sits between the pixel source (frame buffer / pattern generator) and the VGA output register, and streams one pixel per clock with fixed latency.

---
 rtl/pixel_filter_pipe_if.sv | 14 +
 rtl/pixel_filter_pipe.sv | 158 +++++++++++++++
 tb/tb_pixel_filter_pipe.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_filter_pipe_if.sv
// Pixel stream bundle: one pixel per beat, with a valid strobe and a first-of-frame flag.
// The producer uses the master modport and the consumer uses the slave modport.
interface pixel_filter_pipe_if #(
  parameter int CW = 4
);
  logic          valid;
  logic          sof;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;

  modport master (output valid, sof, r, g, b);
  modport slave  (input  valid, sof, r, g, b);
endinterface

// File: rtl/pixel_filter_pipe.sv
// Two-stage per-pixel colour filter (mask, then pass/gray/invert/threshold).
// Switch settings are synchronised and latched only on the first pixel of a frame.
module pixel_filter_pipe #(
  parameter int CW  = 4,
  parameter int FCW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_filter_pipe_if.slave   in_px,
  pixel_filter_pipe_if.master  out_px,
  input  logic                 sw_mask_r,
  input  logic                 sw_mask_g,
  input  logic                 sw_mask_b,
  input  logic [1:0]           sw_mode,
  input  logic [CW-1:0]        sw_thr,
  output logic [FCW-1:0]       frame_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_GRAY   = 2'b01,
    MODE_INVERT = 2'b10,
    MODE_THRESH = 2'b11
  } mode_t;

  // Mask bit order is {r, g, b}.
  typedef struct packed {
    logic [2:0]    mask;
    logic [1:0]    mode;
    logic [CW-1:0] thr;
  } cfg_t;

  localparam logic [CW-1:0] THR_RST = {1'b1, {(CW-1){1'b0}}};
  localparam cfg_t          CFG_RST = '{mask: 3'b000, mode: 2'b00, thr: THR_RST};
  localparam logic [CW-1:0] PIX_MAX = '1;

  cfg_t sw_raw;
  cfg_t sw_meta;
  cfg_t pend_cfg;
  cfg_t act_cfg;
  cfg_t sel_cfg;

  logic          sof_take;
  logic [CW-1:0] mask_r;
  logic [CW-1:0] mask_g;
  logic [CW-1:0] mask_b;
  logic [CW+1:0] sum;

  logic          s1_valid;
  logic          s1_sof;
  logic [CW-1:0] s1_r;
  logic [CW-1:0] s1_g;
  logic [CW-1:0] s1_b;
  logic [CW+1:0] s1_sum;
  mode_t         s1_mode;
  logic [CW-1:0] s1_thr;

  logic [CW-1:0] gray;
  logic [CW-1:0] res_r;
  logic [CW-1:0] res_g;
  logic [CW-1:0] res_b;

  assign sw_raw   = '{mask: {sw_mask_r, sw_mask_g, sw_mask_b}, mode: sw_mode, thr: sw_thr};
  assign sof_take = in_px.valid && in_px.sof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta   <= CFG_RST;
      pend_cfg  <= CFG_RST;
      act_cfg   <= CFG_RST;
      frame_cnt <= '0;
    end else begin
      sw_meta  <= sw_raw;
      pend_cfg <= sw_meta;
      if (sof_take) begin
        act_cfg   <= pend_cfg;
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  // The SOF pixel must already see the config it is loading.
  always_comb begin
    sel_cfg = sof_take ? pend_cfg : act_cfg;
    mask_r  = sel_cfg.mask[2] ? '0 : in_px.r;
    mask_g  = sel_cfg.mask[1] ? '0 : in_px.g;
    mask_b  = sel_cfg.mask[0] ? '0 : in_px.b;
    sum     = {2'b00, mask_r} + {1'b0, mask_g, 1'b0} + {2'b00, mask_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_sum   <= '0;
      s1_mode  <= MODE_PASS;
      s1_thr   <= THR_RST;
    end else begin
      s1_valid <= in_px.valid;
      s1_sof   <= sof_take;
      if (in_px.valid) begin
        s1_r    <= mask_r;
        s1_g    <= mask_g;
        s1_b    <= mask_b;
        s1_sum  <= sum;
        s1_mode <= mode_t'(sel_cfg.mode);
        s1_thr  <= sel_cfg.thr;
      end
    end
  end

  always_comb begin
    gray  = s1_sum[CW+1:2];
    res_r = s1_r;
    res_g = s1_g;
    res_b = s1_b;
    case (s1_mode)
      MODE_GRAY: begin
        res_r = gray;
        res_g = gray;
        res_b = gray;
      end
      MODE_INVERT: begin
        res_r = PIX_MAX - s1_r;
        res_g = PIX_MAX - s1_g;
        res_b = PIX_MAX - s1_b;
      end
      MODE_THRESH: begin
        res_r = (gray >= s1_thr) ? PIX_MAX : '0;
        res_g = res_r;
        res_b = res_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_px.valid <= 1'b0;
      out_px.sof   <= 1'b0;
      out_px.r     <= '0;
      out_px.g     <= '0;
      out_px.b     <= '0;
    end else begin
      out_px.valid <= s1_valid;
      out_px.sof   <= s1_valid && s1_sof;
      if (s1_valid) begin
        out_px.r <= res_r;
        out_px.g <= res_g;
        out_px.b <= res_b;
      end
    end
  end

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Directed bench for pixel_filter_pipe (CW=4, FCW=2): modes, masks, frame-boundary config
// loading, frame counter wrap and asynchronous reset with pixels in flight.
module tb_pixel_filter_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_mask_r, sw_mask_g, sw_mask_b;
  logic [1:0] sw_mode;
  logic [3:0] sw_thr;
  logic [1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [13:0] got;
  logic [13:0] exp;

  pixel_filter_pipe_if #(.CW(4)) in_if ();
  pixel_filter_pipe_if #(.CW(4)) out_if ();

  pixel_filter_pipe #(.CW(4), .FCW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_px     (in_if),
    .out_px    (out_if),
    .sw_mask_r (sw_mask_r),
    .sw_mask_g (sw_mask_g),
    .sw_mask_b (sw_mask_b),
    .sw_mode   (sw_mode),
    .sw_thr    (sw_thr),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic s,
                               input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    @(negedge clk);
    in_if.valid = v;
    in_if.sof   = s;
    in_if.r     = r;
    in_if.g     = g;
    in_if.b     = b;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  // Leaves the bench on the negedge where this pixel is on the outputs.
  task automatic sendPixel(input logic s, input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b);
    applyStimulus(1'b1, s, r, g, b);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    got = {out_if.valid, out_if.sof, out_if.r, out_if.g, out_if.b};
  endtask

  task automatic setSwitches(input logic mr, input logic mg, input logic mb,
                             input logic [1:0] mode, input logic [3:0] thr);
    sw_mask_r = mr;
    sw_mask_g = mg;
    sw_mask_b = mb;
    sw_mode   = mode;
    sw_thr    = thr;
    idle(3);
  endtask

  task automatic test_reset;
    idle(2);
    got = {out_if.valid, out_if.sof, out_if.r, out_if.g, out_if.b};
    checks++;
    if (got !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_out got=%h exp=%h", got, 14'd0);
    end
    checks++;
    if (frame_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough;
    logic [3:0] pr[10] = '{4'd3, 4'd0, 4'd15, 4'd0, 4'd1, 4'd5, 4'd8, 4'd10, 4'd14, 4'd0};
    logic [3:0] pg[10] = '{4'd9, 4'd0, 4'd15, 4'd0, 4'd2, 4'd6, 4'd4, 4'd11, 4'd13, 4'd0};
    logic [3:0] pb[10] = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd3, 4'd7, 4'd2, 4'd12, 4'd12, 4'd0};
    logic       pv[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] hold = 12'd0;
    setSwitches(1'b0, 1'b0, 1'b0, 2'b00, 4'd8);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        if (pv[i-2]) begin
          hold = {pr[i-2], pg[i-2], pb[i-2]};
          exp  = {1'b1, (i == 2), hold};
        end else begin
          exp = {2'b00, hold};
        end
        got = {out_if.valid, out_if.sof, out_if.r, out_if.g, out_if.b};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL pass_slot%0d got=%h exp=%h", i - 2, got, exp);
        end
      end
      if (i < 10) begin
        in_if.valid = pv[i];
        in_if.sof   = (i == 0);
        in_if.r     = pr[i];
        in_if.g     = pg[i];
        in_if.b     = pb[i];
      end else begin
        in_if.valid = 1'b0;
        in_if.sof   = 1'b0;
      end
    end
  endtask

  task automatic test_gray;
    setSwitches(1'b0, 1'b0, 1'b0, 2'b01, 4'd8);
    sendPixel(1'b1, 4'd4, 4'd8, 4'd12);
    exp = {2'b11, 4'd8, 4'd8, 4'd8};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL gray_4_8_12 got=%h exp=%h", got, exp); end
    sendPixel(1'b0, 4'd15, 4'd15, 4'd15);
    exp = {2'b10, 4'd15, 4'd15, 4'd15};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL gray_max got=%h exp=%h", got, exp); end
    setSwitches(1'b0, 1'b1, 1'b0, 2'b01, 4'd8);
    sendPixel(1'b1, 4'd4, 4'd8, 4'd12);
    exp = {2'b11, 4'd4, 4'd4, 4'd4};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL gray_mask_g got=%h exp=%h", got, exp); end
  endtask

  task automatic test_invert_thresh;
    setSwitches(1'b0, 1'b0, 1'b1, 2'b10, 4'd8);
    sendPixel(1'b1, 4'd1, 4'd2, 4'd7);
    exp = {2'b11, 4'd14, 4'd13, 4'd15};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL invert_mask_b got=%h exp=%h", got, exp); end
    setSwitches(1'b0, 1'b0, 1'b0, 2'b11, 4'd8);
    sendPixel(1'b1, 4'd8, 4'd8, 4'd8);
    exp = {2'b11, 4'd15, 4'd15, 4'd15};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL thr_equal got=%h exp=%h", got, exp); end
    sendPixel(1'b0, 4'd7, 4'd7, 4'd7);
    exp = {2'b10, 4'd0, 4'd0, 4'd0};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL thr_below got=%h exp=%h", got, exp); end
    setSwitches(1'b0, 1'b0, 1'b0, 2'b11, 4'd0);
    sendPixel(1'b1, 4'd0, 4'd0, 4'd0);
    exp = {2'b11, 4'd15, 4'd15, 4'd15};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL thr_zero got=%h exp=%h", got, exp); end
  endtask

  task automatic test_midframe;
    setSwitches(1'b0, 1'b0, 1'b0, 2'b00, 4'd8);
    sendPixel(1'b1, 4'd4, 4'd8, 4'd12);
    exp = {2'b11, 4'd4, 4'd8, 4'd12};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mid_sof_pass got=%h exp=%h", got, exp); end
    setSwitches(1'b0, 1'b0, 1'b0, 2'b01, 4'd8);
    sendPixel(1'b0, 4'd4, 4'd8, 4'd12);
    exp = {2'b10, 4'd4, 4'd8, 4'd12};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mid_frame_hold got=%h exp=%h", got, exp); end
    sendPixel(1'b1, 4'd4, 4'd8, 4'd12);
    exp = {2'b11, 4'd8, 4'd8, 4'd8};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mid_next_sof got=%h exp=%h", got, exp); end
    sendPixel(1'b0, 4'd0, 4'd4, 4'd0);
    exp = {2'b10, 4'd2, 4'd2, 4'd2};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL mid_later got=%h exp=%h", got, exp); end
  endtask

  task automatic test_frame_cnt;
    logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (frame_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL cnt_after_reset got=%0d exp=0", frame_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      sendPixel(1'b1, 4'd1, 4'd1, 4'd1);
      checks++;
      if (frame_cnt !== exp_cnt[i]) begin
        errors++;
        $display("[TB] FAIL cnt_step%0d got=%0d exp=%0d", i, frame_cnt, exp_cnt[i]);
      end
    end
    applyStimulus(1'b0, 1'b1, 4'd1, 4'd1, 4'd1);
    idle(2);
    checks++;
    if (frame_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL cnt_sof_no_valid got=%0d exp=1", frame_cnt);
    end
  endtask

  task automatic test_reset_midflight;
    setSwitches(1'b0, 1'b0, 1'b0, 2'b01, 4'd8);
    applyStimulus(1'b1, 1'b1, 4'd4, 4'd8, 4'd12);
    applyStimulus(1'b1, 1'b0, 4'd15, 4'd15, 4'd15);
    applyStimulus(1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
    got = {out_if.valid, out_if.sof, out_if.r, out_if.g, out_if.b};
    exp = {2'b11, 4'd8, 4'd8, 4'd8};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rst_pre got=%h exp=%h", got, exp); end
    #1 rst = 1'b1;
    #1;
    got = {out_if.valid, out_if.sof, out_if.r, out_if.g, out_if.b};
    checks++;
    if (got !== 14'd0 || frame_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rst_immediate got=%h cnt=%0d exp=0 cnt=0", got, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_if.valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_flushed%0d got=%b exp=0", i, out_if.valid);
      end
    end
    sendPixel(1'b0, 4'd4, 4'd8, 4'd12);
    exp = {2'b10, 4'd4, 4'd8, 4'd12};
    checks++;
    if (got !== exp) begin errors++; $display("[TB] FAIL rst_pass_after got=%h exp=%h", got, exp); end
  endtask

  initial begin
    rst         = 1'b1;
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
    in_if.r     = 4'd0;
    in_if.g     = 4'd0;
    in_if.b     = 4'd0;
    sw_mask_r   = 1'b0;
    sw_mask_g   = 1'b0;
    sw_mask_b   = 1'b0;
    sw_mode     = 2'b00;
    sw_thr      = 4'd8;
    test_reset;
    test_passthrough;
    test_gray;
    test_invert_thresh;
    test_midframe;
    test_frame_cnt;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
